// File: rtl/data_mem_access_pkg.sv
// Shared encodings for the MEM-stage data-memory access path: register-write
// modes, store types, and the access controller's state codes.
package data_mem_access_pkg;

  localparam logic [2:0] NOREGWRITE = 3'd0;
  localparam logic [2:0] LB         = 3'd1;
  localparam logic [2:0] LH         = 3'd2;
  localparam logic [2:0] LW         = 3'd3;
  localparam logic [2:0] LBU        = 3'd4;
  localparam logic [2:0] LHU        = 3'd5;

  localparam logic [1:0] SNONE = 2'd0;
  localparam logic [1:0] SB    = 2'd1;
  localparam logic [1:0] SH    = 2'd2;
  localparam logic [1:0] SW    = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Byte stores can land on any lane; halves and words must be naturally aligned.
  function automatic logic store_misaligned(input logic [1:0] storeType,
                                            input logic [1:0] addrLo);
    case (storeType)
      SH:      return addrLo[0];
      SW:      return addrLo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_fmt.sv
// Places store data onto the byte lanes of a 32-bit memory word and produces
// the matching byte enables; also flags stores that cannot be done in one word.
module store_lane_fmt
  import data_mem_access_pkg::*;
(
  input  logic [1:0]  storeType_i,
  input  logic [1:0]  addrLo_i,
  input  logic [31:0] data_i,
  output logic [3:0]  we_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  // Data is replicated across lanes so the memory simply picks the enabled bytes.
  always_comb begin
    we_o         = 4'b0000;
    wdata_o      = 32'h0;
    misaligned_o = store_misaligned(storeType_i, addrLo_i);
    case (storeType_i)
      SB: begin
        we_o    = 4'b0001 << addrLo_i;
        wdata_o = {4{data_i[7:0]}};
      end
      SH: begin
        we_o    = addrLo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{data_i[15:0]}};
      end
      SW: begin
        we_o    = 4'b1111;
        wdata_o = data_i;
      end
      default: begin
        we_o    = 4'b0000;
        wdata_o = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_access.sv
// MEM-stage data-memory access controller: issues word-addressed, byte-enabled
// transactions on a variable-latency port, stalls until done, feeds the W stage.
module data_mem_access
  import data_mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] alu_out_m,
  input  logic [31:0]       store_data_m,
  input  logic [1:0]        store_type_m,
  input  logic [2:0]        reg_write_m,
  input  logic              is_load_m,
  input  logic              flush_w,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              stall_m,
  output logic              misalign,
  output logic [31:0]       data_w,
  output logic [1:0]        byte_sel_w,
  output logic [2:0]        reg_write_w
);

  state_e            state_q, state_d;
  logic [ADDR_W-3:0] addr_q;
  logic [3:0]        we_q;
  logic [31:0]       wdata_q;
  logic [1:0]        byteSel_q;
  logic [2:0]        regWrite_q;
  logic              isLoad_q;

  logic [31:0]       dataW_q;
  logic [1:0]        byteSelW_q;
  logic [2:0]        regWriteW_q;

  logic [3:0]        fmtWe;
  logic [31:0]       fmtWdata;
  logic              fmtMisaligned;
  logic              opValid;
  logic              misStore;
  logic              accept;
  logic              loadDone;

  store_lane_fmt uLaneFmt (
    .storeType_i  (store_type_m),
    .addrLo_i     (alu_out_m[1:0]),
    .data_i       (store_data_m),
    .we_o         (fmtWe),
    .wdata_o      (fmtWdata),
    .misaligned_o (fmtMisaligned)
  );

  assign opValid  = is_load_m || (store_type_m != SNONE);
  assign misStore = !is_load_m && fmtMisaligned;
  assign accept   = (state_q == IDLE) && opValid && !misStore;
  assign loadDone = (state_q == WAIT) && mem_rvalid;

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    stall_m  = 1'b0;
    misalign = 1'b0;
    case (state_q)
      IDLE: begin
        if (opValid && misStore) begin
          misalign = 1'b1;
        end else if (opValid) begin
          stall_m = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        stall_m = !(mem_ready && !isLoad_q);
        if (mem_ready) begin
          state_d = isLoad_q ? WAIT : IDLE;
        end
      end
      WAIT: begin
        // Read data is only accepted from the cycle after the request was taken.
        stall_m = !mem_rvalid;
        if (mem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      we_q       <= 4'b0000;
      wdata_q    <= 32'h0;
      byteSel_q  <= 2'b00;
      regWrite_q <= NOREGWRITE;
      isLoad_q   <= 1'b0;
    end else if (accept) begin
      addr_q     <= alu_out_m[ADDR_W-1:2];
      we_q       <= is_load_m ? 4'b0000 : fmtWe;
      wdata_q    <= is_load_m ? 32'h0 : fmtWdata;
      byteSel_q  <= alu_out_m[1:0];
      regWrite_q <= reg_write_m;
      isLoad_q   <= is_load_m;
    end
  end

  // Flush beats a completing load; a stalled M stage sends a bubble instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataW_q     <= 32'h0;
      byteSelW_q  <= 2'b00;
      regWriteW_q <= NOREGWRITE;
    end else if (flush_w) begin
      dataW_q     <= 32'h0;
      regWriteW_q <= NOREGWRITE;
    end else if (loadDone) begin
      dataW_q     <= mem_rdata;
      byteSelW_q  <= byteSel_q;
      regWriteW_q <= regWrite_q;
    end else if (stall_m) begin
      regWriteW_q <= NOREGWRITE;
    end else if (!is_load_m) begin
      dataW_q     <= 32'h0;
      byteSelW_q  <= alu_out_m[1:0];
      regWriteW_q <= misStore ? NOREGWRITE : reg_write_m;
    end else begin
      regWriteW_q <= NOREGWRITE;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_we      = we_q;
  assign mem_wdata   = wdata_q;
  assign data_w      = dataW_q;
  assign byte_sel_w  = byteSelW_q;
  assign reg_write_w = regWriteW_q;

endmodule

// File: tb/tb_data_mem_access.sv
// Randomised self-checking bench for data_mem_access: a transaction-level model
// predicts every cycle's outputs; directed cases pin literal values.
module tb_data_mem_access;
  import data_mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_out_m = '0;
  logic [31:0] store_data_m = '0;
  logic [1:0]  store_type_m = SNONE;
  logic [2:0]  reg_write_m = NOREGWRITE;
  logic        is_load_m = 1'b0;
  logic        flush_w = 1'b0;
  logic        mem_req;
  logic        mem_ready = 1'b0;
  logic [29:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall_m;
  logic        misalign;
  logic [31:0] data_w;
  logic [1:0]  byte_sel_w;
  logic [2:0]  reg_write_w;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;
  int flushPct = 0;

  bit          expReq, expStall, expMis, expChkWdata;
  logic [29:0] expAddr;
  logic [3:0]  expWe;
  logic [31:0] expWdata;
  logic [31:0] mdlDataW = '0;
  logic [1:0]  mdlByteSelW = '0;
  logic [2:0]  mdlRegWriteW = NOREGWRITE;

  data_mem_access #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_out_m    (alu_out_m),
    .store_data_m (store_data_m),
    .store_type_m (store_type_m),
    .reg_write_m  (reg_write_m),
    .is_load_m    (is_load_m),
    .flush_w      (flush_w),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .stall_m      (stall_m),
    .misalign     (misalign),
    .data_w       (data_w),
    .byte_sel_w   (byte_sel_w),
    .reg_write_w  (reg_write_w)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: mid-cycle, every cycle the model has an expectation for.
  always @(negedge clk) begin
    if (checkEn && !rst) begin
      checkOutput("stall_m", 32'(stall_m), 32'(expStall));
      checkOutput("misalign", 32'(misalign), 32'(expMis));
      checkOutput("mem_req", 32'(mem_req), 32'(expReq));
      if (expReq) begin
        checkOutput("mem_addr", 32'(mem_addr), 32'(expAddr));
        checkOutput("mem_we", 32'(mem_we), 32'(expWe));
        if (expChkWdata) checkOutput("mem_wdata", mem_wdata, expWdata);
      end
      checkOutput("reg_write_w", 32'(reg_write_w), 32'(mdlRegWriteW));
      checkOutput("byte_sel_w", 32'(byte_sel_w), 32'(mdlByteSelW));
      checkOutput("data_w", data_w, mdlDataW);
    end
  end

  function automatic logic randFlush();
    return ($urandom_range(99) < flushPct);
  endfunction

  // Byte lanes covered by an aligned access of 'size' bytes, data repeated per lane group.
  task automatic laneModel(input int size, input int off, input logic [31:0] d,
                           output logic [3:0] we, output logic [31:0] wd);
    int base;
    base = (off / size) * size;
    for (int i = 0; i < 4; i++) begin
      we[i] = (i >= base) && (i < base + size);
      wd[8*i +: 8] = d[8*(i % size) +: 8];
    end
  endtask

  // One clock with the current inputs; afterwards update the W-stage model.
  task automatic stepCycle(input bit eReq, input bit eStall, input bit eMis, input bit complete);
    expReq   = eReq;
    expStall = eStall;
    expMis   = eMis;
    checkEn  = 1'b1;
    @(posedge clk);
    #1;
    if (flush_w) begin
      mdlRegWriteW = NOREGWRITE;
      mdlDataW     = '0;
    end else if (complete) begin
      mdlDataW     = mem_rdata;
      mdlByteSelW  = alu_out_m[1:0];
      mdlRegWriteW = reg_write_m;
    end else if (eStall) begin
      mdlRegWriteW = NOREGWRITE;
    end else begin
      mdlRegWriteW = eMis ? NOREGWRITE : reg_write_m;
      mdlByteSelW  = alu_out_m[1:0];
      mdlDataW     = '0;
    end
  endtask

  task automatic idleCycle(input logic [2:0] rw);
    is_load_m    = 1'b0;
    store_type_m = SNONE;
    reg_write_m  = rw;
    alu_out_m    = $urandom;
    store_data_m = $urandom;
    mem_ready    = 1'($urandom);
    mem_rvalid   = 1'($urandom);
    mem_rdata    = $urandom;
    flush_w      = randFlush();
    stepCycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Runs one memory instruction through M, with chosen memory latencies.
  task automatic applyStimulus(input bit isLoad, input logic [1:0] st, input logic [2:0] rw,
                               input logic [31:0] addr, input logic [31:0] d,
                               input int readyDly, input int rvDly,
                               input logic [31:0] rdata, input bit flushDone);
    int size;
    bit mis;
    logic [3:0] we;
    logic [31:0] wd;
    if (isLoad) size = (rw == LB || rw == LBU) ? 1 : (rw == LH || rw == LHU) ? 2 : 4;
    else        size = (st == SB) ? 1 : (st == SH) ? 2 : 4;
    mis = !isLoad && ((int'(addr[1:0]) % size) != 0);
    laneModel(size, int'(addr[1:0]), d, we, wd);
    expAddr      = addr[31:2];
    expWe        = isLoad ? 4'b0000 : we;
    expWdata     = wd;
    expChkWdata  = !isLoad;
    alu_out_m    = addr;
    store_data_m = d;
    store_type_m = isLoad ? SNONE : st;
    reg_write_m  = rw;
    is_load_m    = isLoad;
    mem_ready    = 1'($urandom);
    mem_rvalid   = 1'($urandom);
    mem_rdata    = $urandom;
    flush_w      = randFlush();
    if (mis) begin
      stepCycle(1'b0, 1'b0, 1'b1, 1'b0);
      return;
    end
    stepCycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < readyDly; i++) begin
      mem_ready  = 1'b0;
      mem_rvalid = 1'($urandom);
      flush_w    = randFlush();
      stepCycle(1'b1, 1'b1, 1'b0, 1'b0);
    end
    mem_ready  = 1'b1;
    mem_rvalid = 1'($urandom);
    flush_w    = randFlush();
    stepCycle(1'b1, isLoad, 1'b0, 1'b0);
    if (isLoad) begin
      mem_ready = 1'($urandom);
      for (int i = 0; i < rvDly; i++) begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        flush_w    = randFlush();
        stepCycle(1'b0, 1'b1, 1'b0, 1'b0);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      flush_w    = flushDone;
      stepCycle(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    #22;
    checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_misalign", 32'(misalign), 32'h0);
    checkOutput("rst_data_w", data_w, 32'h0);
    checkOutput("rst_byte_sel_w", 32'(byte_sel_w), 32'h0);
    checkOutput("rst_reg_write_w", 32'(reg_write_w), 32'(NOREGWRITE));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // LB at a lane-3 offset, immediate ready, data one cycle later.
    applyStimulus(1'b1, SNONE, LB, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234, 1'b0);
    checkOutput("lb_data_w", data_w, 32'h80FF_1234);
    checkOutput("lb_byte_sel_w", 32'(byte_sel_w), 32'h3);
    checkOutput("lb_reg_write_w", 32'(reg_write_w), 32'(LB));
    checkOutput("lb_mem_addr", 32'(mem_addr), 32'h400);
    checkOutput("lb_mem_we", 32'(mem_we), 32'h0);

    // SB to lane 2.
    applyStimulus(1'b0, SB, NOREGWRITE, 32'h0000_2002, 32'h0000_00A5, 0, 0, 32'h0, 1'b0);
    checkOutput("sb_mem_we", 32'(mem_we), 32'h4);
    checkOutput("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    checkOutput("sb_mem_addr", 32'(mem_addr), 32'h800);
    checkOutput("sb_reg_write_w", 32'(reg_write_w), 32'(NOREGWRITE));

    // Misaligned SW: no request is latched, retires as NOREGWRITE.
    applyStimulus(1'b0, SW, LW, 32'h0000_2001, 32'h1111_2222, 0, 0, 32'h0, 1'b0);
    checkOutput("sw_mis_reg_write_w", 32'(reg_write_w), 32'(NOREGWRITE));
    checkOutput("sw_mis_mem_addr", 32'(mem_addr), 32'h800);

    // SH to the upper half with a slow memory.
    applyStimulus(1'b0, SH, NOREGWRITE, 32'h0000_000E, 32'h1234_BEEF, 3, 0, 32'h0, 1'b0);
    checkOutput("sh_mem_addr", 32'(mem_addr), 32'h3);
    checkOutput("sh_mem_we", 32'(mem_we), 32'hC);
    checkOutput("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);

    // LW abandoned by reset while waiting for data; the late response is ignored.
    expAddr = 30'h40; expWe = 4'b0000; expChkWdata = 1'b0;
    alu_out_m = 32'h0000_0100; is_load_m = 1'b1; reg_write_m = LW; store_type_m = SNONE;
    mem_ready = 1'b1; mem_rvalid = 1'b0; flush_w = 1'b0;
    stepCycle(1'b0, 1'b1, 1'b0, 1'b0);
    stepCycle(1'b1, 1'b1, 1'b0, 1'b0);
    is_load_m = 1'b0; reg_write_m = NOREGWRITE; mem_ready = 1'b0;
    checkEn = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("lwrst_mem_req", 32'(mem_req), 32'h0);
    checkOutput("lwrst_stall_m", 32'(stall_m), 32'h0);
    checkOutput("lwrst_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("lwrst_reg_write_w", 32'(reg_write_w), 32'(NOREGWRITE));
    checkOutput("lwrst_data_w", data_w, 32'h0);
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    rst = 1'b0;
    @(posedge clk);
    #1;
    mdlRegWriteW = NOREGWRITE;
    mdlDataW     = '0;
    mdlByteSelW  = alu_out_m[1:0];
    checkOutput("lwrst_late_data_w", data_w, 32'h0);
    checkOutput("lwrst_late_reg_write_w", 32'(reg_write_w), 32'(NOREGWRITE));
    idleCycle(NOREGWRITE);

    // LHU whose completion coincides with a W flush.
    applyStimulus(1'b1, SNONE, LHU, 32'h0000_0022, 32'h0, 1, 2, 32'hCAFE_0001, 1'b1);
    checkOutput("lhuflush_reg_write_w", 32'(reg_write_w), 32'(NOREGWRITE));
    checkOutput("lhuflush_data_w", data_w, 32'h0);
    checkOutput("lhuflush_mem_req", 32'(mem_req), 32'h0);
    applyStimulus(1'b0, SW, NOREGWRITE, 32'h0000_0040, 32'h0BAD_F00D, 0, 0, 32'h0, 1'b0);

    flushPct = 12;
    for (int n = 0; n < 200; n++) begin
      logic isLd;
      isLd = 1'($urandom);
      if (isLd)
        applyStimulus(1'b1, SNONE, 3'($urandom_range(5, 1)), $urandom, $urandom,
                      $urandom_range(3), $urandom_range(3), $urandom, ($urandom_range(3) == 0));
      else
        applyStimulus(1'b0, 2'($urandom_range(3, 1)), NOREGWRITE, $urandom, $urandom,
                      $urandom_range(3), 0, 32'h0, 1'b0);
      for (int g = 0; g < int'($urandom_range(2)); g++) idleCycle(3'($urandom_range(5)));
    end

    checkEn = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
